// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader and its skid buffer.
// The optional delivered-word counter is enabled with FIFO_STREAM_READER_CNT_EN.
package fifo_stream_reader_pkg;

   localparam int SKID_DEPTH = 2;
   localparam int CNT_WIDTH  = 16;

   typedef enum logic [0:0] {
      ST_ACTIVE = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

   // Credit is evaluated in 3 bits: the add happens before the subtract so it never wraps.
   function automatic logic credit_avail(input logic [1:0] occ,
                                         input logic       inflight,
                                         input logic       pop);
      logic [2:0] sum;
      sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      return (sum < 3'(SKID_DEPTH));
   endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry register skid buffer: head in entry0, tail in entry1, strict FIFO order.
// Built for the FIFO_STREAM_READER_CNT_EN-configurable fifo_stream_reader.
module fifo_stream_skid
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [1:0]            occ,
   output logic [1:0]            occ_nxt,
   output logic                  head_valid,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] entry0_r;
   logic [DATA_WIDTH-1:0] entry1_r;
   logic [1:0]            occ_r;
   logic                  valid_r;

   logic [DATA_WIDTH-1:0] entry0_nxt_s;
   logic [DATA_WIDTH-1:0] entry1_nxt_s;
   logic [1:0]            occ_nxt_s;
   logic [1:0]            slot_s;
   logic                  pop_ok_s;
   logic                  push_ok_s;

   // Next-state: shift on pop, then write the captured word into the first free slot.
   always_comb begin
      entry0_nxt_s = entry0_r;
      entry1_nxt_s = entry1_r;
      slot_s       = occ_r;
      pop_ok_s     = pop & (occ_r != 2'd0);
      if (pop_ok_s) begin
         entry0_nxt_s = entry1_r;
         entry1_nxt_s = '0;
         slot_s       = occ_r - 2'd1;
      end else begin
         slot_s       = occ_r;
      end
      push_ok_s = push & (slot_s < 2'(SKID_DEPTH));
      if (push_ok_s) begin
         case (slot_s)
            2'd0:    entry0_nxt_s = push_data;
            2'd1:    entry1_nxt_s = push_data;
            default: entry1_nxt_s = entry1_nxt_s;
         endcase
      end else begin
         entry1_nxt_s = entry1_nxt_s;
      end
      occ_nxt_s = occ_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
   end

   // Buffer storage, occupancy and registered head-valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry0_r <= '0;
         entry1_r <= '0;
         occ_r    <= 2'd0;
         valid_r  <= 1'b0;
      end else begin
         entry0_r <= entry0_nxt_s;
         entry1_r <= entry1_nxt_s;
         occ_r    <= occ_nxt_s;
         valid_r  <= (occ_nxt_s != 2'd0);
      end
   end

   assign occ        = occ_r;
   assign occ_nxt    = occ_nxt_s;
   assign head_valid = valid_r;
   assign head_data  = entry0_r;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side companion for Synchronous_FIFO: pops words into a full-rate valid/ready stream.
// Define FIFO_STREAM_READER_CNT_EN to add the 16-bit rd_count delivered-word counter.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  rd_en,
   input  logic                  EMPTY,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  halt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy
`ifdef FIFO_STREAM_READER_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

   state_e                state_r;
   state_e                state_nxt_s;
   logic                  inflight_r;
   logic                  busy_r;
   logic                  rd_en_s;
   logic                  pop_s;
   logic [1:0]            occ_s;
   logic [1:0]            occ_nxt_s;
   logic                  head_valid_s;
   logic [DATA_WIDTH-1:0] head_data_s;

   assign pop_s = head_valid_s & out_ready;

   // Read strobe: only path from out_ready to an output, via the pop term of the credit.
   always_comb begin
      rd_en_s = 1'b0;
      if ((state_r == ST_ACTIVE) && !EMPTY) begin
         rd_en_s = credit_avail(occ_s, inflight_r, pop_s);
      end else begin
         rd_en_s = 1'b0;
      end
   end

   // Halt is sampled at the edge, so it stops reads from the following cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_ACTIVE: begin
            if (halt) state_nxt_s = ST_HALTED;
            else      state_nxt_s = ST_ACTIVE;
         end
         ST_HALTED: begin
            if (!halt) state_nxt_s = ST_ACTIVE;
            else       state_nxt_s = ST_HALTED;
         end
         default: state_nxt_s = ST_ACTIVE;
      endcase
   end

   // FSM state, in-flight read marker and registered busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_ACTIVE;
         inflight_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         inflight_r <= rd_en_s;
         busy_r     <= rd_en_s | (occ_nxt_s != 2'd0);
      end
   end

   // The in-flight word is captured unconditionally; the credit rule reserved its slot.
   fifo_stream_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (inflight_r),
      .push_data  (fifo_data),
      .pop        (pop_s),
      .occ        (occ_s),
      .occ_nxt    (occ_nxt_s),
      .head_valid (head_valid_s),
      .head_data  (head_data_s)
   );

`ifdef FIFO_STREAM_READER_CNT_EN
   logic [CNT_WIDTH-1:0] rd_count_r;

   // Delivered-word counter, wraps naturally at its width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count_r <= '0;
      end else if (pop_s) begin
         rd_count_r <= rd_count_r + 16'd1;
      end else begin
         rd_count_r <= rd_count_r;
      end
   end

   assign rd_count = rd_count_r;
`endif

   assign rd_en     = rd_en_s;
   assign out_valid = head_valid_s;
   assign out_data  = head_data_s;
   assign busy      = busy_r;

endmodule
